// File: rtl/fc_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_scheduler
// Brief    : Time-multiplexes one fully-connected MAC node over all output
//            nodes of a layer: bias fetch, weight stream, result write-back.
// Revision : 1.0
// ============================================================================
module fc_layer_scheduler #(
    parameter int DATA_WIDTH         = 32,
    parameter int NUMBER_INPUT_NODE  = 5,
    parameter int NUMBER_OUTPUT_NODE = 3,
    parameter int WEIGHT_ADDR_WIDTH  = 16,
    parameter int OUT_ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES     = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_error,
    output logic                         o_bias_rd,
    output logic [OUT_ADDR_WIDTH-1:0]    o_bias_addr,
    input  logic [DATA_WIDTH-1:0]        i_bias_data,
    output logic                         o_weight_rd,
    output logic [WEIGHT_ADDR_WIDTH-1:0] o_weight_addr,
    input  logic [DATA_WIDTH-1:0]        i_weight_data,
    output logic                         o_node_start,
    output logic [DATA_WIDTH-1:0]        o_node_bias,
    output logic [DATA_WIDTH-1:0]        o_node_weight,
    output logic                         o_node_weight_valid,
    input  logic [DATA_WIDTH-1:0]        i_node_data,
    input  logic                         i_node_valid,
    output logic                         o_wr_en,
    output logic [OUT_ADDR_WIDTH-1:0]    o_wr_addr,
    output logic [DATA_WIDTH-1:0]        o_wr_data
);

    localparam int c_K_W = (NUMBER_INPUT_NODE > 1) ? $clog2(NUMBER_INPUT_NODE) : 1;
    localparam int c_T_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_K_W-1:0]             c_K_LAST  = c_K_W'(NUMBER_INPUT_NODE - 1);
    localparam logic [c_K_W-1:0]             c_K_ONE   = c_K_W'(1);
    localparam logic [c_T_W-1:0]             c_T_LAST  = c_T_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_T_W-1:0]             c_T_ONE   = c_T_W'(1);
    localparam logic [OUT_ADDR_WIDTH-1:0]    c_N_LAST  = OUT_ADDR_WIDTH'(NUMBER_OUTPUT_NODE - 1);
    localparam logic [OUT_ADDR_WIDTH-1:0]    c_N_ONE   = OUT_ADDR_WIDTH'(1);
    localparam logic [WEIGHT_ADDR_WIDTH-1:0] c_WA_ONE  = WEIGHT_ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_BIAS = 3'd1,
        S_STREAM    = 3'd2,
        S_WAIT      = 3'd3,
        S_WRITE     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t                         state_q, state_d;
    logic [OUT_ADDR_WIDTH-1:0]      n_q, n_d;
    logic [c_K_W-1:0]               k_q, k_d;
    logic [c_T_W-1:0]               cnt_q, cnt_d;
    logic [WEIGHT_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic                           err_q, err_d;
    logic [DATA_WIDTH-1:0]          bias_q, bias_d;
    logic [DATA_WIDTH-1:0]          result_q, result_d;
    logic                           wvalid_q, wvalid_d;
    logic                           w_first_stream;

    // Streams run back to back across nodes, so a running address equals n*NI+k.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            waddr_q  <= '0;
            err_q    <= 1'b0;
            bias_q   <= '0;
            result_q <= '0;
            wvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            waddr_q  <= waddr_d;
            err_q    <= err_d;
            bias_q   <= bias_d;
            result_q <= result_d;
            wvalid_q <= wvalid_d;
        end
    end

    assign w_first_stream = (state_q == S_STREAM) && (k_q == '0);

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        waddr_d  = waddr_q;
        err_d    = err_q;
        bias_d   = bias_q;
        result_d = result_q;
        wvalid_d = (state_q == S_STREAM);
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    n_d     = '0;
                    waddr_d = '0;
                    err_d   = 1'b0;
                    state_d = S_LOAD_BIAS;
                end
            end
            S_LOAD_BIAS: begin
                k_d     = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (w_first_stream) begin
                    bias_d = i_bias_data;
                end
                waddr_d = waddr_q + c_WA_ONE;
                k_d     = k_q + c_K_ONE;
                if (k_q == c_K_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving on the final allowed cycle still wins over timeout.
                if (i_node_valid) begin
                    result_d = i_node_data;
                    state_d  = S_WRITE;
                end else if (cnt_q == c_T_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + c_T_ONE;
                end
            end
            S_WRITE: begin
                if (n_q == c_N_LAST) begin
                    state_d = S_DONE;
                end else begin
                    n_d     = n_q + c_N_ONE;
                    state_d = S_LOAD_BIAS;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy              = (state_q != S_IDLE);
    assign o_done              = (state_q == S_DONE);
    assign o_error             = err_q;
    assign o_bias_rd           = (state_q == S_LOAD_BIAS);
    assign o_bias_addr         = n_q;
    assign o_weight_rd         = (state_q == S_STREAM);
    assign o_weight_addr       = waddr_q;
    assign o_node_start        = w_first_stream;
    // Bias is forwarded on the start cycle, then held from the register.
    assign o_node_bias         = w_first_stream ? i_bias_data : bias_q;
    assign o_node_weight       = wvalid_q ? i_weight_data : '0;
    assign o_node_weight_valid = wvalid_q;
    assign o_wr_en             = (state_q == S_WRITE);
    assign o_wr_addr           = n_q;
    assign o_wr_data           = result_q;

endmodule
`default_nettype wire
